// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight producers and picks operand forward sources / load-use stalls.
// Optional stall-cycle counter is built only when FWD_STALL_CNT_EN is defined.
module forward_scoreboard #(
  parameter int REG_ADDR_W = 3,
  parameter int STAGES     = 3,
  localparam int SEL_W     = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic [REG_ADDR_W-1:0] id_src_b,
  input  logic                  id_src_b_used,
  output logic [SEL_W-1:0]      forward_a,
  output logic [SEL_W-1:0]      forward_b,
  output logic                  stall,
  output logic [15:0]           stall_cnt
);

  // Index k-1 holds entry k (the instruction k stages ahead of ID).
  logic [STAGES-1:0]                 valid_q, valid_d;
  logic [STAGES-1:0]                 reg_write_q, reg_write_d;
  logic [STAGES-1:0]                 is_load_q, is_load_d;
  logic [STAGES-1:0][REG_ADDR_W-1:0] dst_q, dst_d;

  logic [SEL_W-1:0] sel_a, sel_b;
  logic             load_a, load_b;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    load_a = 1'b0;
    load_b = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (valid_q[k-1] && reg_write_q[k-1] && (dst_q[k-1] != '0)) begin
        if (dst_q[k-1] == id_src_a) begin
          sel_a  = SEL_W'(k);
          load_a = is_load_q[k-1];
        end
        if (dst_q[k-1] == id_src_b) begin
          sel_b  = SEL_W'(k);
          load_b = is_load_q[k-1];
        end
      end
    end
  end

  always_comb begin
    stall     = id_valid &&
                (((sel_a == SEL_W'(1)) && load_a) ||
                 (id_src_b_used && (sel_b == SEL_W'(1)) && load_b));
    forward_a = stall ? '0 : sel_a;
    forward_b = (stall || !id_src_b_used) ? '0 : sel_b;
  end

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    dst_d       = dst_q;
    if (flush) begin
      valid_d = '0;
    end else if (advance) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        valid_d[k]     = valid_q[k-1];
        reg_write_d[k] = reg_write_q[k-1];
        is_load_d[k]   = is_load_q[k-1];
        dst_d[k]       = dst_q[k-1];
      end
      // A stalled ID instruction stays put; a bubble enters entry 1 instead.
      valid_d[0]     = id_valid && !stall;
      reg_write_d[0] = stall ? 1'b0 : id_reg_write;
      is_load_d[0]   = stall ? 1'b0 : id_is_load;
      dst_d[0]       = stall ? '0 : id_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      reg_write_q <= '0;
      is_load_q   <= '0;
      dst_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
      dst_q       <= dst_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && advance && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
